// File: rtl/peg_pkt_rx_buf.sv
// Store-and-forward packet receive buffer: packets are written speculatively and
// only become visible to egress once their eop beat commits a good packet.
module peg_pkt_rx_buf #(
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ingr_sop,
  input  logic              ingr_eop,
  input  logic              ingr_valid,
  input  logic              ingr_error,
  input  logic [DATA_W-1:0] ingr_data,
  output logic              ingr_ready,
  output logic              egr_sop,
  output logic              egr_eop,
  output logic              egr_valid,
  output logic              egr_error,
  output logic [DATA_W-1:0] egr_data,
  input  logic              egr_ready,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic [DEPTH_W:0]  fill_lvl,
  output logic [1:0]        fsm_state
);

  // Handshake: on both sides a beat moves only in a cycle where valid and ready
  // are both 1; egress holds valid/data/eop stable while stalled.

  localparam logic [DEPTH_W:0] FULL_LVL = {1'b1, {DEPTH_W{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DISCARD = 2'd2} state_t;

  state_t             state, state_n;
  logic [DATA_W:0]    mem [FULL_LVL];
  logic [DEPTH_W:0]   wptr, wptr_n, wptr_s, wptr_s_n, wptr_c, rptr;
  logic [DEPTH_W:0]   commit_ptr, waddr, end_ptr, occ;
  logic               commit_pend, commit, bad, bad_n, pkt_bad;
  logic               we, accept, full, ovf, start_pkt, cont, rd_en, sop_flag;
  logic [1:0]         drops;
  logic [16:0]        drop_sum;

  // wptr_s marks the start of the open packet; wptr_c lags it by one cycle.
  assign occ        = wptr - wptr_s;
  assign full       = (wptr - rptr) == FULL_LVL;
  assign ovf        = (state == RECV) && (occ == FULL_LVL);
  assign ingr_ready = !rst && (!full || ovf || state == DISCARD);
  assign accept     = ingr_valid && ingr_ready;
  assign fsm_state  = state;
  assign fill_lvl   = wptr_c - rptr;
  assign egr_error  = 1'b0;
  assign egr_sop    = egr_valid && sop_flag;
  assign drop_sum   = {1'b0, drop_cnt} + {15'd0, drops};

  always_comb begin
    state_n   = state;
    wptr_n    = wptr;
    wptr_s_n  = wptr_s;
    bad_n     = bad;
    we        = 1'b0;
    waddr     = wptr;
    end_ptr   = wptr;
    pkt_bad   = 1'b0;
    commit    = 1'b0;
    drops     = 2'd0;
    start_pkt = 1'b0;
    cont      = 1'b0;
    unique case (state)
      IDLE: if (accept && ingr_sop) start_pkt = 1'b1;
      RECV: begin
        if (ovf) begin
          drops   = drops + 2'd1;
          wptr_n  = wptr_s;
          state_n = DISCARD;
          if (accept) begin
            if (ingr_sop) start_pkt = 1'b1;
            else if (ingr_eop) state_n = IDLE;
          end
        end else if (accept) begin
          if (ingr_sop) begin
            drops     = drops + 2'd1;
            start_pkt = 1'b1;
          end else begin
            cont = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept) begin
          if (ingr_sop) start_pkt = 1'b1;
          else if (ingr_eop) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start_pkt || cont) begin
      we      = 1'b1;
      waddr   = start_pkt ? wptr_s : wptr;
      end_ptr = waddr + 1'b1;
      pkt_bad = ingr_error || (cont && bad);
      wptr_n  = end_ptr;
      bad_n   = pkt_bad;
      state_n = RECV;
      if (ingr_eop) begin
        state_n = IDLE;
        if (pkt_bad) begin
          wptr_n = wptr_s;
          drops  = drops + 2'd1;
        end else begin
          commit   = 1'b1;
          wptr_s_n = end_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr[DEPTH_W-1:0]] <= {ingr_eop, ingr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wptr        <= '0;
      wptr_s      <= '0;
      wptr_c      <= '0;
      commit_ptr  <= '0;
      commit_pend <= 1'b0;
      bad         <= 1'b0;
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      wptr        <= wptr_n;
      wptr_s      <= wptr_s_n;
      bad         <= bad_n;
      commit_pend <= commit;
      if (commit) commit_ptr <= end_ptr;
      if (commit_pend) wptr_c <= commit_ptr;
      if (commit && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // The output register is the RAM read register, giving one cycle of read latency.
  assign rd_en = (rptr != wptr_c) && (!egr_valid || egr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      egr_valid <= 1'b0;
      egr_eop   <= 1'b0;
      egr_data  <= '0;
      sop_flag  <= 1'b1;
    end else begin
      if (egr_valid && egr_ready) sop_flag <= egr_eop;
      if (rd_en) begin
        egr_valid           <= 1'b1;
        {egr_eop, egr_data} <= mem[rptr[DEPTH_W-1:0]];
        rptr                <= rptr + 1'b1;
      end else if (egr_ready) begin
        egr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peg_pkt_rx_buf.sv
// Bench for peg_pkt_rx_buf: packet-level reference model feeding an expected queue,
// egress monitor popping and comparing, directed scenarios then random traffic.
module tb_peg_pkt_rx_buf;

  localparam int DATA_W  = 16;
  localparam int DEPTH_W = 2;
  localparam int DEPTH   = 4;

  logic              clk, rst;
  logic              ingr_sop, ingr_eop, ingr_valid, ingr_error;
  logic [DATA_W-1:0] ingr_data;
  logic              ingr_ready;
  logic              egr_sop, egr_eop, egr_valid, egr_error;
  logic [DATA_W-1:0] egr_data;
  logic              egr_ready;
  logic [15:0]       pkt_cnt, drop_cnt;
  logic [DEPTH_W:0]  fill_lvl;
  logic [1:0]        fsm_state;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W-1:0] open_q[$];
  bit                in_pkt, open_bad;
  int                exp_pkt, exp_drop, eop_cyc;
  bit                prev_stall;
  logic [DATA_W:0]   prev_word;

  peg_pkt_rx_buf #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst(rst),
    .ingr_sop(ingr_sop), .ingr_eop(ingr_eop), .ingr_valid(ingr_valid),
    .ingr_error(ingr_error), .ingr_data(ingr_data), .ingr_ready(ingr_ready),
    .egr_sop(egr_sop), .egr_eop(egr_eop), .egr_valid(egr_valid),
    .egr_error(egr_error), .egr_data(egr_data), .egr_ready(egr_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .fill_lvl(fill_lvl),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: egr_ready = 1'b1;
      1: egr_ready = ~egr_ready;
      2: egr_ready = 1'($urandom_range(0, 1));
      default: egr_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // reference model: works on whole packets built from accepted beats
  task automatic model_flush();
    exp_q.delete();
    open_q.delete();
    in_pkt = 0;
    open_bad = 0;
    exp_pkt = 0;
    exp_drop = 0;
  endtask

  task automatic model_beat(input logic s, input logic e, input logic er,
                            input logic [DATA_W-1:0] d);
    if (s) begin
      if (in_pkt) exp_drop++;
      in_pkt = 1;
      open_q.delete();
      open_bad = 0;
    end
    if (in_pkt) begin
      open_q.push_back(d);
      open_bad = open_bad | er;
      if (e) begin
        in_pkt = 0;
        eop_cyc = cyc;
        if (open_bad) exp_drop++;
        else begin
          exp_pkt++;
          foreach (open_q[i])
            exp_q.push_back({1'(i == 0), 1'(i == open_q.size() - 1), open_q[i]});
        end
      end else if (open_q.size() == DEPTH) begin
        exp_drop++;
        in_pkt = 0;
      end
    end
  endtask

  always @(negedge clk)
    if (!rst && ingr_valid && ingr_ready)
      model_beat(ingr_sop, ingr_eop, ingr_error, ingr_data);

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [DATA_W+1:0] e;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall)
        chk("egress_hold", {egr_valid, egr_eop, egr_data}, {1'b1, prev_word});
      if (egr_valid && egr_ready) begin
        chk("egr_error", egr_error, 0);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got sop=%0b eop=%0b data=0x%0h, expected no beat",
                   egr_sop, egr_eop, egr_data);
        end else begin
          e = exp_q.pop_front();
          chk("egress_beat", {egr_sop, egr_eop, egr_data}, e);
        end
      end
      prev_stall = egr_valid && !egr_ready;
      prev_word  = {egr_eop, egr_data};
    end
  end

  // driver tasks (entered and left just after a rising edge)
  task automatic send_beat(input logic s, input logic e, input logic er,
                           input logic [DATA_W-1:0] d, input int gap);
    int w = 0;
    ingr_valid = 1; ingr_sop = s; ingr_eop = e; ingr_error = er; ingr_data = d;
    forever begin
      @(negedge clk);
      if (ingr_ready) break;
      w++;
      if (w > 5000) begin
        total++;
        $display("FAIL ingress_timeout: got no ready in %0d cycles, expected ready", w);
        break;
      end
    end
    @(posedge clk); #1;
    ingr_valid = 0; ingr_sop = 0; ingr_eop = 0; ingr_error = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int len, input int err_idx, input logic [DATA_W-1:0] first);
    for (int i = 0; i < len; i++)
      send_beat(i == 0, i == len - 1, i == err_idx, first + DATA_W'(i), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    model_flush();
    @(posedge clk);
    @(negedge clk);
    chk("rst_egress", {egr_valid, egr_sop, egr_eop, egr_error, egr_data}, 0);
    chk("rst_counters", {pkt_cnt, drop_cnt}, 0);
    chk("rst_fill", fill_lvl, 0);
    chk("rst_ready", ingr_ready, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int len, errb;
    bit trunc;
    rst = 1; ingr_valid = 0; ingr_sop = 0; ingr_eop = 0; ingr_error = 0;
    ingr_data = '0; egr_ready = 1;
    model_flush();
    @(posedge clk); #1;
    do_reset();

    // 4-beat packet, latency from eop acceptance to first egress beat
    send_pkt(4, -1, 16'h0001);
    w = 0;
    forever begin
      @(negedge clk);
      if (egr_valid || w > 20) break;
      w++;
    end
    chk("t1_latency", 32'(cyc - eop_cyc), 3);
    wait_drain();
    chk("t1_pkt_cnt", pkt_cnt, 1);
    chk("t1_drop_cnt", drop_cnt, 0);

    // errored packet is dropped
    do_reset();
    send_pkt(3, 1, 16'h0100);
    wait_drain();
    chk("t2_drop_cnt", drop_cnt, 1);
    chk("t2_pkt_cnt", pkt_cnt, 0);
    chk("t2_fill_lvl", fill_lvl, 0);

    // oversize packet overflows, following packet intact
    do_reset();
    send_pkt(6, -1, 16'h0200);
    send_pkt(2, -1, 16'h0300);
    wait_drain();
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_pkt_cnt", pkt_cnt, 1);

    // second sop abandons the open packet
    do_reset();
    send_beat(1, 0, 0, 16'h0401, 0);
    send_beat(0, 0, 0, 16'h0402, 0);
    send_beat(1, 1, 0, 16'h0403, 0);
    wait_drain();
    chk("t4_drop_cnt", drop_cnt, 1);
    chk("t4_pkt_cnt", pkt_cnt, 1);

    // toggling egress backpressure over back-to-back packets
    do_reset();
    rdy_mode = 1;
    send_pkt(3, -1, 16'h0500);
    send_pkt(4, -1, 16'h0510);
    send_pkt(2, -1, 16'h0520);
    rdy_mode = 0;
    wait_drain();
    chk("t5_pkt_cnt", pkt_cnt, 3);
    chk("t5_fill_lvl", fill_lvl, 0);

    // reset with committed packets buffered and one packet open
    do_reset();
    rdy_mode = 3;
    send_pkt(1, -1, 16'h0600);
    send_pkt(2, -1, 16'h0610);
    send_beat(1, 0, 0, 16'h0620, 3);
    chk("t6_pkt_before_rst", pkt_cnt, 2);
    rdy_mode = 0;
    do_reset();
    send_pkt(2, -1, 16'h0700);
    wait_drain();
    chk("t6_pkt_cnt", pkt_cnt, 1);
    chk("t6_drop_cnt", drop_cnt, 0);

    // random traffic against the model
    do_reset();
    for (int p = 0; p < 80; p++) begin
      if (p % 10 == 0) rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        send_beat(0, 1'($urandom_range(0, 1)), 0, DATA_W'($urandom_range(0, 65535)),
                  $urandom_range(0, 1));
      end else begin
        len   = $urandom_range(1, 6);
        errb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        trunc = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < len; i++) begin
          if (trunc && i == len - 1) break;
          send_beat(i == 0, i == len - 1, i == errb, DATA_W'($urandom_range(0, 65535)),
                    $urandom_range(0, 1));
        end
      end
    end
    rdy_mode = 0;
    wait_drain();
    chk("rand_pkt_cnt", pkt_cnt, 32'(exp_pkt));
    chk("rand_drop_cnt", drop_cnt, 32'(exp_drop));
    chk("rand_fill_lvl", fill_lvl, 0);
    chk("rand_egr_idle", egr_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/peg_pkt_rx_buf.md
PEG_PKT_RX_BUF -- requirements
Module: peg_pkt_rx_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the packet data width in bits.
REQ-002 The block SHALL have parameter DEPTH_W, default 8, giving the buffer depth as 2**DEPTH_W words.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ingr_sop, ingr_eop, ingr_valid, ingr_error  input  1 each  ingress packet side, slave role.
REQ-006 ingr_data  input  DATA_W  ingress beat data.
REQ-007 ingr_ready  output  1  ingress backpressure.
REQ-008 egr_sop, egr_eop, egr_valid, egr_error  output  1 each  egress packet side, master role.
REQ-009 egr_data  output  DATA_W  egress beat data.
REQ-010 egr_ready  input  1  egress backpressure.
REQ-011 pkt_cnt  output  16  count of committed packets; saturates at 0xFFFF.
REQ-012 drop_cnt  output  16  count of dropped packets; saturates at 0xFFFF.
REQ-013 fill_lvl  output  DEPTH_W+1  committed words not yet read from RAM.

Function
REQ-014 Handshake on both sides: a beat transfers only in a cycle where valid and ready are both 1.
REQ-015 The block SHALL act as a store-and-forward buffer: no beat of a packet appears on egress before that packet's eop beat is accepted and committed.
REQ-016 Each RAM word SHALL hold {eop, data}, DATA_W+1 bits wide.
REQ-017 The write side SHALL keep a speculative pointer wptr and a committed pointer wptr_c; the read side SHALL keep rptr; all pointers are DEPTH_W+1 bits, and the full/empty decision uses the MSB.
REQ-018 ingr_ready SHALL be 1 unless the buffer is full (wptr - rptr == 2**DEPTH_W) or the block is in reset.
REQ-019 The ingress FSM SHALL have three states: IDLE, RECV and DISCARD.
REQ-020 IDLE: an accepted beat with sop=1 writes at wptr; if eop=1 on the same beat it is a one-beat packet (commit per REQ-023); otherwise the FSM goes to RECV.
REQ-021 IDLE: an accepted beat with sop=0 SHALL be dropped silently, with no write and no counter change.
REQ-022 RECV: each accepted beat writes at wptr and increments wptr; an error=1 on any beat marks the packet bad.
REQ-023 Commit on an eop beat: if the packet is good, wptr_c SHALL take the post-write wptr on the next cycle, pkt_cnt SHALL increment, and the FSM returns to IDLE.
REQ-024 Bad packet at eop: wptr SHALL rewind to wptr_c, drop_cnt SHALL increment, and the FSM returns to IDLE.
REQ-025 RECV, sop=1 received again: the open packet SHALL be dropped (rewind, drop_cnt+1) and the new beat written as the first beat at wptr_c in the same cycle.
REQ-026 Overflow: if the buffer is full while in RECV and the open packet occupies all 2**DEPTH_W words, the block SHALL rewind, increment drop_cnt, keep ingr_ready at 1 and go to DISCARD; otherwise ingr_ready simply stays 0.
REQ-027 DISCARD: all beats SHALL be accepted and ignored up to and including eop, then the FSM returns to IDLE; a sop seen in DISCARD is handled as in REQ-020.
REQ-028 The egress side SHALL use a one-entry output register fed by a 1-cycle-latency RAM read.
REQ-029 The output register SHALL load when rptr != wptr_c and the register is empty or being drained in that cycle.
REQ-030 egr_valid, egr_data and egr_eop SHALL stay stable while egr_valid=1 and egr_ready=0.
REQ-031 egr_sop SHALL be 1 on the first beat after reset and on the first beat after any beat with egr_eop=1.
REQ-032 egr_error SHALL be constant 0.
REQ-033 Latency: with egress idle and egr_ready=1, the first beat of a packet SHALL appear with egr_valid=1 exactly 3 cycles after the cycle its eop is accepted.
REQ-034 Egress SHALL sustain 1 beat per cycle while committed data is available.
REQ-035 A write and a read in the same cycle SHALL both take effect; fill_lvl = wptr_c - rptr.

Reset
REQ-036 On rst=1 at a clock edge: all pointers, pkt_cnt, drop_cnt, fill_lvl, egr_* and ingr_ready SHALL be 0, and the FSM SHALL go to IDLE.
REQ-037 Reset mid-packet SHALL discard all buffered and partial data; after reset the first valid egress beat SHALL carry egr_sop=1.

Verification
REQ-038 Directed: 4-beat packet 0x0001..0x0004 with egr_ready=1 -> egress shows the same 4 beats, sop on 0x0001, eop on 0x0004, first beat 3 cycles after ingress eop; pkt_cnt=1.
REQ-039 Directed: 3-beat packet with error=1 on beat 2 -> no egress activity; drop_cnt=1; fill_lvl=0.
REQ-040 Directed: DEPTH_W=2, 6-beat packet -> drop_cnt=1, no egress; a following 2-beat packet is delivered intact.
REQ-041 Directed: sop, 2 beats, then a second sop starting a 1-beat packet {sop,eop} -> only the 1-beat packet is output; drop_cnt=1, pkt_cnt=1.
REQ-042 Directed: egr_ready toggling 1/0 every cycle across 3 back-to-back packets -> data is held stable while stalled and no beats are lost or duplicated; pkt_cnt=3.
REQ-043 Directed: assert rst mid-packet with 2 committed packets buffered -> all outputs are 0 next cycle; a new packet afterwards is output with egr_sop=1.
